// File: rtl/mul_pkg.sv
// Shared constants and FSM state type for the mul_seq64 shift-and-add multiplier.
package mul_pkg;

  // Operand/result width; the datapath is only defined for 64.
  localparam int WIDTH   = 64;
  // Step counter width: must hold the value 64.
  localparam int COUNT_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : mul_pkg

// File: rtl/adder64.sv
// 64-bit adder used for the partial-product accumulate; carry-out is dropped so
// the sum wraps modulo 2^64.
module adder64 (
  input  logic [63:0] A,
  input  logic [63:0] B,
  output logic [63:0] sum
);

  assign sum = A + B;

endmodule : adder64

// File: rtl/mul_seq64.sv
// Sequential 64x64 -> low-64 multiplier (ARM MUL semantics), one shift-and-add
// step per clock. The low 64 bits of a product do not depend on operand sign,
// so two's complement operands go through the unsigned datapath unchanged.
//
// Build option: define MUL_EARLY_TERM_EN to finish as soon as the remaining
// multiplier bits are all zero. Without it, every multiply takes 64 steps.
module mul_seq64 #(
  parameter int WIDTH = mul_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  import mul_pkg::*;

  state_t             r_state;
  logic [WIDTH-1:0]   r_prod;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [COUNT_W-1:0] r_count;

  logic [WIDTH-1:0]   w_sum;
  logic               w_last_step;
  logic               w_early_stop;

  adder64 u_adder64 (
    .A   (r_prod),
    .B   (r_mcand),
    .sum (w_sum)
  );

  // The step taken while count is 63 is the 64th and final one.
  assign w_last_step = (r_count == COUNT_W'(WIDTH - 1));

`ifdef MUL_EARLY_TERM_EN
  // No multiplier bits left: further steps would add nothing.
  assign w_early_stop = (r_mplier == '0);
`else
  assign w_early_stop = 1'b0;
`endif

  // FSM plus shift-and-add datapath; start is only honoured outside RUN.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears the datapath too, so an aborted
    // multiply leaves result at zero rather than a partial product.
    if (reset) begin
      r_state  <= ST_IDLE;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees the values from
      // before this edge, independent of statement order.
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_mcand  <= A;
            r_mplier <= B;
            r_prod   <= '0;
            r_count  <= '0;
            r_state  <= ST_RUN;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (w_early_stop) begin
            r_state <= ST_DONE;
          end else begin
            if (r_mplier[0]) begin
              r_prod <= w_sum;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 1'b1;
            if (w_last_step) begin
              r_state <= ST_DONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are direct decodes of state and the accumulator.
  assign result = r_prod;
  assign busy   = (r_state == ST_RUN);
  assign done   = (r_state == ST_DONE);

endmodule : mul_seq64
